mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter_rr_arb2.sv | 9 +
 rtl/mem_arbiter.sv | 99 +++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, FSM encoding and requester ids for mem_arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_CAP  = 2'd3
  } state_t;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant favouring the requester not granted last
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);
  assign o_grant[0] = i_valid[0] & (~i_valid[1] | i_last_grant);
  assign o_grant[1] = i_valid[1] & (~i_valid[0] | ~i_last_grant);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two requesters sharing one registered-read memory port, one transaction at a time
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_w_en,
  output logic              mem_r_en,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t r_state;
  logic r_last;
  logic r_id;
  logic r_wr;
  logic [1:0] w_grant;
  logic w_sel;
  logic w_hs;
  logic w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  rr_arb2 u_rr (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last),
    .o_grant      (w_grant)
  );
  assign req0_ready = (r_state == S_IDLE) & w_grant[0];
  assign req1_ready = (r_state == S_IDLE) & w_grant[1];
  assign w_hs = (req0_ready & req0_valid) | (req1_ready & req1_valid);
  assign w_sel = w_grant[1];
  assign w_wr = w_sel ? req1_wr : req0_wr;
  assign w_addr = w_sel ? req1_addr : req0_addr;
  assign w_wdata = w_sel ? req1_wdata : req0_wdata;
  // FSM with the command register doubling as the memory port drive, plus response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last <= REQ1;
      r_id <= REQ0;
      r_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_w_en <= 1'b0;
      mem_r_en <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      mem_w_en <= 1'b0;
      mem_r_en <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_hs) begin
          r_state <= S_ISSUE;
          r_last <= w_sel;
          r_id <= w_sel;
          r_wr <= w_wr;
          mem_addr <= w_addr;
          mem_wdata <= w_wdata;
          mem_w_en <= w_wr;
          mem_r_en <= ~w_wr;
        end
        S_ISSUE: r_state <= r_wr ? S_IDLE : S_RD_WAIT;
        S_RD_WAIT: r_state <= S_RD_CAP;
        S_RD_CAP: begin
          r_state <= S_IDLE;
          if (r_id == REQ1) begin
            rsp1_rdata <= mem_rdata;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_rdata <= mem_rdata;
            rsp0_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus random checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0_valid = 1'b0, req0_wr = 1'b0, req0_ready;
  logic req1_valid = 1'b0, req1_wr = 1'b0, req1_ready;
  logic [6:0] req0_addr = '0, req1_addr = '0, mem_addr;
  logic [7:0] req0_wdata = '0, req1_wdata = '0, mem_wdata, mem_rdata;
  logic rsp0_valid, rsp1_valid, mem_w_en, mem_r_en;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [7:0] mem [128];
  int checks = 0;
  int errors = 0;
  int cyc, next_free, hs_cyc;
  bit hs_ok, hs_wr, hs_id, ref_last;
  logic [6:0] hs_addr;
  logic [7:0] hs_wdata;
  logic [7:0] ref_mem [128];
  logic [7:0] exp_rd [2];
  int grants[$];
  int hs_cycs[$];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // external 128x8 memory with registered read, cleared by reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_w_en) mem[mem_addr] <= mem_wdata;
      if (mem_r_en) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    next_free = 0;
    ref_last = 1'b1;
    hs_ok = 1'b0;
    hs_cyc = -100;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_rsp0v", rsp0_valid, 0);
    chk("rst_rsp1v", rsp1_valid, 0);
    chk("rst_rsp0d", rsp0_rdata, 0);
    chk("rst_rsp1d", rsp1_rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wen", mem_w_en, 0);
    chk("rst_ren", mem_r_en, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // one cycle: compare outputs against the transaction model, then advance it
  task automatic tick();
    bit free, win, r0, r1, rv;
    #1;
    free = cyc >= next_free;
    win = (req0_valid && req1_valid) ? !ref_last : req1_valid;
    r0 = free && req0_valid && !win;
    r1 = free && req1_valid && win;
    chk("ready0", req0_ready, r0);
    chk("ready1", req1_ready, r1);
    chk("w_en", mem_w_en, hs_ok && cyc == hs_cyc + 1 && hs_wr);
    chk("r_en", mem_r_en, hs_ok && cyc == hs_cyc + 1 && !hs_wr);
    chk("mem_addr", mem_addr, hs_ok ? hs_addr : 7'd0);
    chk("mem_wdata", mem_wdata, hs_ok ? hs_wdata : 8'd0);
    rv = hs_ok && !hs_wr && cyc == hs_cyc + 4;
    if (rv) exp_rd[hs_id] = ref_mem[hs_addr];
    chk("rsp0_valid", rsp0_valid, rv && !hs_id);
    chk("rsp1_valid", rsp1_valid, rv && hs_id);
    chk("rsp0_rdata", rsp0_rdata, exp_rd[0]);
    chk("rsp1_rdata", rsp1_rdata, exp_rd[1]);
    if (r0 || r1) begin
      hs_ok = 1'b1;
      hs_cyc = cyc;
      hs_id = win;
      hs_wr = win ? req1_wr : req0_wr;
      hs_addr = win ? req1_addr : req0_addr;
      hs_wdata = win ? req1_wdata : req0_wdata;
      ref_last = win;
      grants.push_back(int'(win));
      hs_cycs.push_back(cyc);
      next_free = cyc + (hs_wr ? 2 : 4);
      if (hs_wr) ref_mem[hs_addr] = hs_wdata;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    // req0 write 0xA5 to address 5
    req0_valid = 1; req0_wr = 1; req0_addr = 7'd5; req0_wdata = 8'hA5;
    tick();
    req0_valid = 0;
    #1;
    chk("wr_t1_wen", mem_w_en, 1);
    chk("wr_t1_addr", mem_addr, 5);
    chk("wr_t1_data", mem_wdata, 8'hA5);
    tick();
    #1;
    chk("wr_t2_wen", mem_w_en, 0);
    tick();
    // req1 read of address 5
    req1_valid = 1; req1_wr = 0; req1_addr = 7'd5;
    tick();
    req1_valid = 0;
    #1;
    chk("rd_t1_ren", mem_r_en, 1);
    repeat (3) tick();
    #1;
    chk("rd_t4_rsp1v", rsp1_valid, 1);
    chk("rd_t4_rsp1d", rsp1_rdata, 8'hA5);
    chk("rd_t4_rsp0v", rsp0_valid, 0);
    tick();
    // contention after reset: alternate grants, one every 2 cycles
    do_reset();
    grants.delete(); hs_cycs.delete();
    req0_valid = 1; req0_wr = 1; req0_addr = 7'd1; req0_wdata = 8'h11;
    req1_valid = 1; req1_wr = 1; req1_addr = 7'd2; req1_wdata = 8'h22;
    repeat (8) tick();
    chk("alt_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      chk("alt_grant", grants[i], i % 2);
      chk("alt_cycle", hs_cycs[i], 2 * i);
    end
    // back-to-back reads by req0, accepted on the response cycle
    grants.delete(); hs_cycs.delete();
    req1_valid = 0;
    req0_wr = 0; req0_addr = 7'd1;
    repeat (12) tick();
    chk("b2b_count", hs_cycs.size(), 3);
    for (int i = 1; i < hs_cycs.size(); i++) chk("b2b_space", hs_cycs[i] - hs_cycs[i-1], 4);
    chk("b2b_data", rsp0_rdata, 8'h11);
    // only req1 valid: granted every time
    req0_valid = 0;
    grants.delete(); hs_cycs.delete();
    req1_valid = 1; req1_wr = 1; req1_addr = 7'd5; req1_wdata = 8'h5A;
    repeat (6) tick();
    chk("solo_count", grants.size(), 3);
    foreach (grants[i]) chk("solo_grant", grants[i], 1);
    req1_valid = 0;
    tick();
    // reset in RD_WAIT abandons the read
    req0_valid = 1; req0_wr = 0; req0_addr = 7'd5;
    tick();
    req0_valid = 0;
    tick();
    #2;
    do_reset();
    repeat (6) begin
      #1;
      chk("abandon_rsp0", rsp0_valid, 0);
      chk("abandon_ren", mem_r_en, 0);
      tick();
    end
    req0_valid = 1; req0_wr = 0; req0_addr = 7'd5;
    tick();
    req0_valid = 0;
    repeat (3) tick();
    #1;
    chk("clr_rsp0v", rsp0_valid, 1);
    chk("clr_rsp0d", rsp0_rdata, 0);
    tick();
    // random traffic
    for (int n = 0; n < 600; n++) begin
      req0_valid = $urandom_range(0, 3) != 0;
      req1_valid = $urandom_range(0, 3) != 0;
      req0_wr = 1'($urandom_range(0, 1));
      req1_wr = 1'($urandom_range(0, 1));
      req0_addr = 7'($urandom_range(0, 15));
      req1_addr = 7'($urandom_range(0, 15));
      req0_wdata = 8'($urandom);
      req1_wdata = 8'($urandom);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
